// File: rtl/cv32e40x_xif_aes_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40x_xif_aes -- shared types for the XIF AES coprocessor slice.
//
// Contents:
//   XIF_ID_WIDTH    width of the instruction ID carried through the ID/rd FIFO
//   id_rd_packet_t  ID/rd FIFO entry {id, rd, we}
//   result_state_e  state encoding of the result transmitter
// -----------------------------------------------------------------------------
package cv32e40x_xif_aes;

    localparam int unsigned XIF_ID_WIDTH = 4;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic [4:0]              rd;
        logic                    we;
    } id_rd_packet_t;

    typedef enum logic {
        RES_IDLE = 1'b0,
        RES_HOLD = 1'b1
    } result_state_e;

endpackage

// File: rtl/cv32e40x_xif_result_tx.sv
// -----------------------------------------------------------------------------
// cv32e40x_xif_result_tx -- XIF result channel transmitter.
//
// Pairs each AES datapath result with the head of the ID/rd FIFO, registers
// the pair and presents it on the XIF result interface until the core takes
// it. A new result may be loaded in the same cycle the held one is accepted,
// so a continuous stream runs at one result per cycle.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            drop any held result, return to idle
//   fifo_empty_i       ID/rd FIFO empty flag
//   fifo_data_i        ID/rd FIFO head entry
//   fifo_pop_o         pop the FIFO head (one per accepted AES result)
//   aes_valid_i        AES result valid
//   aes_data_i         AES result word
//   aes_ready_o        AES result accepted when aes_valid_i is also high
//   result_valid_o     XIF result valid
//   result_ready_i     XIF result ready from the core
//   result_id_o        result instruction ID
//   result_rd_o        destination register
//   result_we_o        register-file write enable
//   result_data_o      result data
//   stall_cnt_o        cycles with result_valid_o=1 and result_ready_i=0
//
// Build option:
//   CV32E40X_XIF_RESULT_STALL_CNT_EN  enables the saturating back-pressure
//   counter; when undefined stall_cnt_o is tied to 0 and no flops are built.
//
// States:
//   state    | meaning
//   RES_IDLE | no result held, result_valid_o = 0
//   RES_HOLD | result registered, result_valid_o = 1
// -----------------------------------------------------------------------------
module cv32e40x_xif_result_tx
    import cv32e40x_xif_aes::*;
#(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFW_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   fifo_empty_i,
    input  id_rd_packet_t          fifo_data_i,
    output logic                   fifo_pop_o,
    input  logic                   aes_valid_i,
    input  logic [X_RFW_WIDTH-1:0] aes_data_i,
    output logic                   aes_ready_o,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [X_ID_WIDTH-1:0]  result_id_o,
    output logic [4:0]             result_rd_o,
    output logic                   result_we_o,
    output logic [X_RFW_WIDTH-1:0] result_data_o,
    output logic [15:0]            stall_cnt_o
);

    result_state_e state_q;
    result_state_e state_d;
    logic          can_take;
    logic          accept;

    // The output slot is free when idle or when the held result leaves this
    // cycle. rst_ni gates the handshake so nothing pops while in reset.
    assign can_take = rst_ni & ~flush_i & ~fifo_empty_i
                      & ((state_q == RES_IDLE) | result_ready_i);
    assign accept   = can_take & aes_valid_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RES_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = RES_IDLE;
        end else if (accept) begin
            state_d = RES_HOLD;
        end else if ((state_q == RES_HOLD) && result_ready_i) begin
            state_d = RES_IDLE;
        end
    end

    // Output logic
    always_comb begin
        result_valid_o = (state_q == RES_HOLD);
        aes_ready_o    = can_take;
        fifo_pop_o     = accept;
    end

    // Result payload; only written on accept so it stays stable under
    // back-pressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_id_o   <= '0;
            result_rd_o   <= '0;
            result_we_o   <= 1'b0;
            result_data_o <= '0;
        end else if (accept) begin
            result_id_o   <= X_ID_WIDTH'(fifo_data_i.id);
            result_rd_o   <= fifo_data_i.rd;
            result_we_o   <= fifo_data_i.we;
            result_data_o <= aes_data_i;
        end
    end

`ifdef CV32E40X_XIF_RESULT_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating; cleared only by reset so it accumulates across flushes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (result_valid_o && !result_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/cv32e40x_xif_result_tx.md
CV32E40X_XIF_RESULT_TX -- requirements
Module: cv32e40x_xif_result_tx

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4, meaning the XIF instruction ID width.
REQ-002 SHALL have parameter X_RFW_WIDTH, default 32, meaning the result data width.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port flush_i, input, 1 bit, to drop any held result and return to idle.
REQ-006 SHALL have port fifo_empty_i, input, 1 bit, the ID/rd FIFO empty flag.
REQ-007 SHALL have port fifo_data_i, input, id_rd_packet_t, the ID/rd FIFO head entry.
REQ-008 SHALL have port fifo_pop_o, output, 1 bit, to pop the ID/rd FIFO head.
REQ-009 SHALL have port aes_valid_i, input, 1 bit, signalling that the AES datapath result is valid.
REQ-010 SHALL have port aes_data_i, input, X_RFW_WIDTH bits, the AES result word.
REQ-011 SHALL have port aes_ready_o, output, 1 bit, to accept the AES result.
REQ-012 SHALL have port result_valid_o, output, 1 bit, the XIF result valid.
REQ-013 SHALL have port result_ready_i, input, 1 bit, the XIF result ready from the core.
REQ-014 SHALL have port result_id_o, output, X_ID_WIDTH bits, the result instruction ID.
REQ-015 SHALL have port result_rd_o, output, 5 bits, the destination register.
REQ-016 SHALL have port result_we_o, output, 1 bit, the register-file write enable.
REQ-017 SHALL have port result_data_o, output, X_RFW_WIDTH bits, the result data.
REQ-018 SHALL have port stall_cnt_o, output, 16 bits, the result back-pressure cycle count.

Function
REQ-019 SHALL implement two states: IDLE (no result held) and HOLD (result registered, result_valid_o=1).
REQ-020 SHALL define the accept condition as accept = !flush_i & !fifo_empty_i & aes_valid_i & (state==IDLE | result_ready_i).
REQ-021 SHALL drive aes_ready_o = !flush_i & !fifo_empty_i & (state==IDLE | result_ready_i), combinationally.
REQ-022 SHALL drive fifo_pop_o = accept, so exactly one pop occurs per accepted AES result.
REQ-023 SHALL, on accept, register fifo_data_i.id, .rd, .we and aes_data_i into the result outputs and enter HOLD at the next edge, giving one cycle of latency.
REQ-024 SHALL, in HOLD with result_ready_i=1 and no accept, enter IDLE and drop result_valid_o at the next edge.
REQ-025 SHALL, in HOLD with result_ready_i=1 and accept, load the new result and stay in HOLD, so back-to-back throughput is 1 result per cycle.
REQ-026 SHALL, in HOLD with result_ready_i=0, hold all result_* outputs stable.
REQ-027 SHALL, when aes_valid_i=1 and fifo_empty_i=1, perform no accept and no pop, keeping aes_ready_o=0.
REQ-028 SHALL, when fifo_empty_i=0 and aes_valid_i=0, perform no pop.
REQ-029 SHALL, on flush_i, force fifo_pop_o=0 and aes_ready_o=0, enter IDLE at the next edge, and clear result_valid_o.
REQ-030 SHALL never let result_valid_o fall in HOLD without either result_ready_i or flush_i.

Reset
REQ-031 SHALL, on asynchronous rst_ni=0, enter state IDLE and set result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o and stall_cnt_o to 0.
REQ-032 SHALL hold fifo_pop_o=0 and aes_ready_o=0 while rst_ni=0.
REQ-033 SHALL discard a held result when reset asserts mid-HOLD, and SHALL leave the state at IDLE after release.

Configuration
REQ-034 SHALL, with CV32E40X_XIF_RESULT_STALL_CNT_EN defined, increment stall_cnt_o each cycle result_valid_o=1 & result_ready_i=0, saturating at 16'hFFFF and clearing only on reset.
REQ-035 SHALL, without CV32E40X_XIF_RESULT_STALL_CNT_EN, tie stall_cnt_o to 0 and instantiate no counter flops.

Structure
REQ-036 SHALL take id_rd_packet_t (fields id[X_ID_WIDTH-1:0], rd[4:0], we) from package cv32e40x_xif_aes, and SHALL place any new result typedefs in that package.
REQ-037 SHALL be a single module with no sub-module; the state machine and counter are inline.

Verification
REQ-038 SHALL cover single result: FIFO head {id=3, rd=10, we=1}, aes_data=0xDEADBEEF, result_ready_i=1 -> pop in cycle 0; result_valid_o=1 in cycle 1 with id=3, rd=10, data=0xDEADBEEF; IDLE in cycle 2.
REQ-039 SHALL cover back-pressure: result_ready_i=0 for 5 cycles -> outputs stable, aes_ready_o=0, no pop, stall_cnt_o=5 (macro on) or 0 (macro off).
REQ-040 SHALL cover back-to-back: 4 queued IDs 0..3, aes_valid_i constant, result_ready_i=1 -> 4 consecutive valid cycles with IDs 0,1,2,3 and 4 pops.
REQ-041 SHALL cover empty FIFO: aes_valid_i=1, fifo_empty_i=1 -> aes_ready_o=0, fifo_pop_o=0, result_valid_o stays 0.
REQ-042 SHALL cover flush mid-HOLD: result_ready_i=0, flush_i pulse -> result_valid_o=0 next cycle, no pop during flush cycle.
REQ-043 SHALL cover reset mid-HOLD: rst_ni low while result_valid_o=1 -> all outputs 0 immediately, IDLE after release.
